count_ones_chunked: RTL and testbench

Parametrised, multi-cycle bit-population counter with a go/done handshake. It processes `CHUNK_WIDTH` bits per cycle and can count either ones or zeros. It can also stop early once the remaining bits contain nothing to count. It is the general-purpose successor to the single-bit-per-cycle count-ones FSMD variants, and sits behind the same start/complete control style in datapath blocks.

---
 rtl/count_ones_chunked.sv | 130 +++++++++++++
 tb/tb_count_ones_chunked.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_ones_chunked.sv
// Multi-cycle population counter consuming CHUNK_WIDTH bits per cycle.
// Counts ones or zeros, with an optional early finish on an all-zero remainder.
module count_ones_chunked #(
  parameter int INPUT_WIDTH  = 32,
  parameter int CHUNK_WIDTH  = 4,
  parameter int EARLY_EXIT   = 1,
  localparam int OUTPUT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic                    count_zeros,
  input  logic [INPUT_WIDTH-1:0]  in,
  output logic [OUTPUT_WIDTH-1:0] out,
  output logic                    done,
  output logic                    busy
);

  localparam int NUM_CHUNKS = INPUT_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PC_W = $clog2(CHUNK_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_CHUNKS - 1);

  generate
    if (INPUT_WIDTH < 1 || CHUNK_WIDTH < 1 ||
        (INPUT_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cfg
      $error("count_ones_chunked: bad INPUT/CHUNK width");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  data_q, data_d;
  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [OUTPUT_WIDTH-1:0] out_q, out_d;
  logic                    done_q, done_d;

  logic [INPUT_WIDTH-1:0]  data_shr;
  logic [CHUNK_WIDTH-1:0]  chunk;
  logic [PC_W-1:0]         chunk_pc;
  logic [OUTPUT_WIDTH-1:0] sum;
  logic                    last;

  // A single-chunk operand has nothing left after the shift.
  generate
    if (CHUNK_WIDTH >= INPUT_WIDTH) begin : g_one_chunk
      assign data_shr = '0;
    end else begin : g_multi_chunk
      assign data_shr = {{CHUNK_WIDTH{1'b0}},
                         data_q[INPUT_WIDTH-1:CHUNK_WIDTH]};
    end
  endgenerate

  assign chunk = data_q[CHUNK_WIDTH-1:0];

  always_comb begin
    chunk_pc = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_pc = chunk_pc + PC_W'(chunk[i]);
    end
  end

  assign sum  = acc_q + OUTPUT_WIDTH'(chunk_pc);
  assign last = (idx_q == LAST_IDX) ||
                ((EARLY_EXIT != 0) && (data_shr == '0));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          data_d  = count_zeros ? ~in : in;
          acc_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        acc_d  = sum;
        data_d = data_shr;
        idx_d  = idx_q + IDX_W'(1);
        if (last) begin
          out_d   = sum;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = (state_q == S_COUNT);

endmodule

// File: tb/tb_count_ones_chunked.sv
// Scoreboard bench for count_ones_chunked: three configurations share one
// stimulus stream; a reference model predicts results and finish edges.
module tb_count_ones_chunked;

  localparam int N = 3;
  localparam int CW [N] = '{4, 4, 32};
  localparam int EE [N] = '{1, 0, 0};

  typedef struct {
    int out;
    int fin;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        go    = 1'b0;
  logic        cz    = 1'b0;
  logic [31:0] din   = '0;

  logic [5:0] out_a  [N];
  logic       done_a [N];
  logic       busy_a [N];

  exp_t sb [N][$];
  int   fin     [N];
  bit   started [N];
  bit   pd      [N];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  count_ones_chunked #(
    .INPUT_WIDTH(32), .CHUNK_WIDTH(4), .EARLY_EXIT(1)
  ) u_ee (
    .clk(clk), .rst_n(rst_n), .go(go), .count_zeros(cz), .in(din),
    .out(out_a[0]), .done(done_a[0]), .busy(busy_a[0])
  );

  count_ones_chunked #(
    .INPUT_WIDTH(32), .CHUNK_WIDTH(4), .EARLY_EXIT(0)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .go(go), .count_zeros(cz), .in(din),
    .out(out_a[1]), .done(done_a[1]), .busy(busy_a[1])
  );

  count_ones_chunked #(
    .INPUT_WIDTH(32), .CHUNK_WIDTH(32), .EARLY_EXIT(0)
  ) u_wide (
    .clk(clk), .rst_n(rst_n), .go(go), .count_zeros(cz), .in(din),
    .out(out_a[2]), .done(done_a[2]), .busy(busy_a[2])
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  // Latency from the chunk position of the highest counted bit.
  function automatic int lat(int i, logic [31:0] eff);
    int hi = -1;
    if (EE[i] == 0) return 32 / CW[i];
    for (int b = 0; b < 32; b++) if (eff[b]) hi = b;
    return (hi < 0) ? 1 : hi / CW[i] + 1;
  endfunction

  function automatic bit any_busy();
    for (int i = 0; i < N; i++)
      if (started[i] && cyc < fin[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: decides acceptance and pushes expectations.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        started[i] = 1'b0;
        fin[i] = 0;
        sb[i].delete();
      end
    end else begin
      logic [31:0] eff;
      exp_t e;
      cyc++;
      eff = cz ? ~din : din;
      for (int i = 0; i < N; i++) begin
        if (go && !(started[i] && (cyc - 1) < fin[i])) begin
          e.out = $countones(eff);
          e.fin = cyc + lat(i, eff);
          fin[i] = e.fin;
          started[i] = 1'b1;
          sb[i].push_back(e);
        end
      end
    end
  end

  // Monitor: handshake levels every cycle, results on each done rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pd[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        chk($sformatf("busy_d%0d", i), int'(busy_a[i]),
            int'(started[i] && cyc < fin[i]));
        chk($sformatf("done_d%0d", i), int'(done_a[i]),
            int'(started[i] && cyc >= fin[i]));
        if (done_a[i] && !pd[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("done_unexpected_d%0d", i), 1, 0);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("out_d%0d", i), int'(out_a[i]), e.out);
            chk($sformatf("finish_edge_d%0d", i), cyc, e.fin);
          end
        end
        pd[i] = done_a[i];
      end
    end
  end

  task automatic pulse(logic [31:0] v, logic z);
    @(negedge clk);
    go = 1'b1; din = v; cz = z;
    @(negedge clk);
    go = 1'b0; din = $urandom; cz = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (any_busy() && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (any_busy()) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_out_d%0d", tag, i), int'(out_a[i]), 0);
      chk($sformatf("%s_done_d%0d", tag, i), int'(done_a[i]), 0);
      chk($sformatf("%s_busy_d%0d", tag, i), int'(busy_a[i]), 0);
    end
  endtask

  initial begin
    logic [31:0] v;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    pulse(32'hFFFF_FFFF, 1'b0);
    wait_idle();
    pulse(32'h0000_000F, 1'b0);
    wait_idle();
    pulse(32'h8000_0000, 1'b0);
    wait_idle();
    pulse(32'h0000_0000, 1'b0);
    wait_idle();
    pulse(32'h0000_FFFF, 1'b1);
    wait_idle();

    // Extra go pulses while the narrow instances are still counting.
    pulse(32'hF000_0000, 1'b0);
    @(negedge clk);
    go = 1'b1; din = 32'h0000_0001;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1; din = 32'h0000_0003;
    @(negedge clk);
    go = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a count.
    pulse(32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    pulse(32'h1234_5678, 1'b0);
    wait_idle();

    // go held high: back-to-back results.
    @(negedge clk);
    go = 1'b1; din = 32'hA5A5_A5A5; cz = 1'b0;
    repeat (40) @(negedge clk);
    go = 1'b0;
    wait_idle();

    for (int n = 0; n < 25; n++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, 31);
      pulse(v, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    wait_idle();

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      go  = 1'($urandom_range(0, 1));
      din = $urandom >> $urandom_range(0, 31);
      cz  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    go = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    for (int i = 0; i < N; i++)
      chk($sformatf("sb_empty_d%0d", i), sb[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
